hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/proc_pkg.sv | 25 ++
 rtl/sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select encodings and the shadow-slot record that mirrors each pipe stage.
package proc_pkg;

  // Slot rd field is sized for the widest register index we expect to track.
  localparam int unsigned RD_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic                rm;
    logic [RD_MAX_W-1:0] rd;
  } slot_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / RAW interlock, branch flush and EX operand-forward select for a
// 5-stage pipeline, with saturating stall and flush event counters.
module hazard_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned NREG_W = 2,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rs,
  input  logic              id_rs_use,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_rm,
  input  logic              mem_take,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_e           state_q, state_d;
  slot_t               exs_q, exs_d, mems_q, mems_d, wbs_q, wbs_d;
  slot_t               id_slot_c;
  logic [1:0]          fwd_q, fwd_d;
  logic [RD_MAX_W-1:0] rs_ext_c;
  logic                id_live_c, ex_match_c, mem_match_c, hazard_c;
  logic                unused_wbs;

  // The instruction sitting in ID right after a flush is the killed slot.
  assign id_live_c   = id_valid && (state_q != ST_FLUSH);
  assign rs_ext_c    = RD_MAX_W'(id_rs);
  assign ex_match_c  = exs_q.valid && exs_q.wr && (exs_q.rd == rs_ext_c);
  assign mem_match_c = mems_q.valid && mems_q.wr && (mems_q.rd == rs_ext_c);
  assign hazard_c    = id_live_c && id_rs_use &&
                       (FWD_EN ? (ex_match_c && exs_q.rm)
                               : (ex_match_c || mem_match_c));

  // WB slot completes the pipeline mirror; no decision depends on it yet.
  assign unused_wbs = ^wbs_q;

  always_comb begin
    state_d = state_q;
    stall   = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (mem_take) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN, ST_LSTALL: begin
          if (hazard_c) begin
            stall   = 1'b0;
            bubble  = 1'b1;
            state_d = ST_LSTALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Downstream stages always move; ID enters EX unless replaced by a bubble.
  always_comb begin
    id_slot_c.valid = id_live_c && !bubble;
    id_slot_c.wr    = id_wr;
    id_slot_c.rm    = id_rm;
    id_slot_c.rd    = RD_MAX_W'(id_rd);
    exs_d  = id_slot_c;
    mems_d = exs_q;
    wbs_d  = mems_q;
    if (flush) begin
      exs_d.valid  = 1'b0;
      mems_d.valid = 1'b0;
    end
    fwd_d = FWD_NONE;
    if (FWD_EN && id_live_c && id_rs_use && !bubble) begin
      if (ex_match_c) begin
        fwd_d = FWD_EXMEM;
      end else if (mem_match_c) begin
        fwd_d = FWD_MEMWB;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      exs_q   <= '0;
      mems_q  <= '0;
      wbs_q   <= '0;
      fwd_q   <= FWD_NONE;
    end else begin
      state_q <= state_d;
      exs_q   <= exs_d;
      mems_q  <= mems_d;
      wbs_q   <= wbs_d;
      fwd_q   <= fwd_d;
    end
  end

  assign fwd = fwd_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (!stall),
    .count_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (flush),
    .count_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding instance and one
// stall-only instance share the same instruction stream.
module tb_hazard_ctrl;

  localparam int unsigned NREG_W = 2;
  localparam int unsigned CNT_W  = 8;

  logic              clock, reset_n;
  logic              id_valid, id_rs_use, id_wr, id_rm, mem_take;
  logic [NREG_W-1:0] id_rs, id_rd;
  logic              stall, bubble, flush;
  logic              stall0, bubble0, flush0;
  logic [1:0]        fwd, fwd0;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
  int unsigned       checks, errors;

  hazard_ctrl #(.NREG_W(NREG_W), .FWD_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_use(id_rs_use), .id_rd(id_rd), .id_wr(id_wr), .id_rm(id_rm),
    .mem_take(mem_take), .stall(stall), .bubble(bubble), .flush(flush),
    .fwd(fwd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.NREG_W(NREG_W), .FWD_EN(1'b0), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_use(id_rs_use), .id_rd(id_rd), .id_wr(id_wr), .id_rm(id_rm),
    .mem_take(mem_take), .stall(stall0), .bubble(bubble0), .flush(flush0),
    .fwd(fwd0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [NREG_W-1:0] rs, input logic use_rs,
                       input logic [NREG_W-1:0] rd, input logic wr, input logic rm);
    id_valid  = 1'b1;
    id_rs     = rs;
    id_rs_use = use_rs;
    id_rd     = rd;
    id_wr     = wr;
    id_rm     = rm;
  endtask

  task automatic nop();
    id_valid  = 1'b0;
    id_rs     = '0;
    id_rs_use = 1'b0;
    id_rd     = '0;
    id_wr     = 1'b0;
    id_rm     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nop();
    mem_take = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mem_take = 1'b0;
    nop();
    reset_n = 1'b0;
    tick();
    chk("rst_stall",  32'(stall),     32'd1);
    chk("rst_bubble", 32'(bubble),    32'd0);
    chk("rst_flush",  32'(flush),     32'd0);
    chk("rst_fwd",    32'(fwd),       32'd0);
    chk("rst_scnt",   32'(stall_cnt), 32'd0);
    chk("rst_fcnt",   32'(flush_cnt), 32'd0);
    chk("rst_stall0", 32'(stall0),    32'd1);
    tick();
    reset_n = 1'b1;

    // Load r1 then add reading r1: one stall, then MEM/WB forward.
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b1); #1;
    chk("lu_ld_stall", 32'(stall), 32'd1);
    tick();
    issue(2'd1, 1'b1, 2'd2, 1'b1, 1'b0); #1;
    chk("lu_stall",  32'(stall),  32'd0);
    chk("lu_bubble", 32'(bubble), 32'd1);
    tick(); #1;
    chk("lu_release",    32'(stall),  32'd1);
    chk("lu_rel_bubble", 32'(bubble), 32'd0);
    chk("lu_fwd_bubble", 32'(fwd),    32'd0);
    tick();
    nop(); #1;
    chk("lu_fwd",  32'(fwd),       32'd2);
    chk("lu_scnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("lu_fwd_clr", 32'(fwd), 32'd0);

    // ALU producer: back-to-back -> 01, one gap -> 10, unused rs -> 00.
    do_reset();
    issue(2'd0, 1'b0, 2'd2, 1'b1, 1'b0); tick();
    issue(2'd2, 1'b1, 2'd3, 1'b1, 1'b0); #1;
    chk("fw1_nostall", 32'(stall), 32'd1);
    tick();
    nop(); #1;
    chk("fw1_fwd", 32'(fwd), 32'd1);
    tick();
    issue(2'd0, 1'b0, 2'd2, 1'b1, 1'b0); tick();
    issue(2'd3, 1'b0, 2'd0, 1'b1, 1'b0); tick();
    issue(2'd2, 1'b1, 2'd3, 1'b1, 1'b0); tick();
    nop(); #1;
    chk("fw2_fwd",  32'(fwd),       32'd2);
    chk("fw_scnt",  32'(stall_cnt), 32'd0);
    tick();
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b0); tick();
    issue(2'd1, 1'b0, 2'd2, 1'b1, 1'b0); tick();
    nop(); #1;
    chk("fw_nouse", 32'(fwd), 32'd0);

    // Taken branch in the same cycle as a load-use hazard.
    do_reset();
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b1); tick();
    issue(2'd1, 1'b1, 2'd2, 1'b1, 1'b0);
    mem_take = 1'b1; #1;
    chk("fl_flush",  32'(flush),  32'd1);
    chk("fl_stall",  32'(stall),  32'd1);
    chk("fl_bubble", 32'(bubble), 32'd1);
    chk("fl_stall0", 32'(stall0), 32'd1);
    tick();
    mem_take = 1'b0;
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b1); #1;
    chk("fls_flush",  32'(flush),     32'd0);
    chk("fls_stall",  32'(stall),     32'd1);
    chk("fls_bubble", 32'(bubble),    32'd0);
    chk("fls_fcnt",   32'(flush_cnt), 32'd1);
    chk("fls_scnt",   32'(stall_cnt), 32'd0);
    tick();
    issue(2'd1, 1'b1, 2'd2, 1'b1, 1'b0); #1;
    chk("fl_killed_ld", 32'(stall), 32'd1);
    tick();
    nop(); #1;
    chk("fl_fwd",  32'(fwd),       32'd0);
    chk("fl_scnt", 32'(stall_cnt), 32'd0);
    chk("fl_fcnt", 32'(flush_cnt), 32'd1);

    // Stall-only instance: ALU write r3 then read r3 -> two stalls.
    do_reset();
    issue(2'd0, 1'b0, 2'd3, 1'b1, 1'b0); tick();
    issue(2'd3, 1'b1, 2'd0, 1'b0, 1'b0); #1;
    chk("nf_stall1",  32'(stall0),  32'd0);
    chk("nf_bubble1", 32'(bubble0), 32'd1);
    chk("fe_nostall", 32'(stall),   32'd1);
    tick(); #1;
    chk("nf_stall2", 32'(stall0), 32'd0);
    chk("fe_fwd",    32'(fwd),    32'd1);
    tick(); #1;
    chk("nf_adv",    32'(stall0),  32'd1);
    chk("nf_adv_bb", 32'(bubble0), 32'd0);
    tick();
    nop(); #1;
    chk("nf_fwd",  32'(fwd0),       32'd0);
    chk("nf_scnt", 32'(stall_cnt0), 32'd2);

    // Reset pulsed while the stall-only instance is holding in LSTALL.
    do_reset();
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b1); tick();
    issue(2'd1, 1'b1, 2'd2, 1'b1, 1'b0); #1;
    chk("rs_pre", 32'(stall0), 32'd0);
    tick(); #1;
    chk("rs_lstall", 32'(stall0), 32'd0);
    reset_n = 1'b0; #1;
    chk("rs_stall0",  32'(stall0),     32'd1);
    chk("rs_bubble0", 32'(bubble0),    32'd0);
    chk("rs_flush0",  32'(flush0),     32'd0);
    chk("rs_scnt0",   32'(stall_cnt0), 32'd0);
    chk("rs_stall",   32'(stall),      32'd1);
    chk("rs_scnt",    32'(stall_cnt),  32'd0);
    #2;
    reset_n = 1'b1; #1;
    chk("rs_noload0", 32'(stall0), 32'd1);
    chk("rs_noload",  32'(stall),  32'd1);
    tick();
    issue(2'd0, 1'b0, 2'd1, 1'b1, 1'b1); tick();
    issue(2'd1, 1'b1, 2'd2, 1'b1, 1'b0); #1;
    chk("rs_newload", 32'(stall), 32'd0);
    tick();

    // Self-dependent load stream: counters climb then saturate.
    do_reset();
    issue(2'd1, 1'b1, 2'd1, 1'b1, 1'b1);
    repeat (20) tick();
    chk("sat_early",  32'(stall_cnt),  32'd10);
    chk("sat_early0", 32'(stall_cnt0), 32'd13);
    repeat (580) tick();
    chk("sat_scnt",  32'(stall_cnt),  32'd255);
    chk("sat_scnt0", 32'(stall_cnt0), 32'd255);
    chk("sat_fcnt",  32'(flush_cnt),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
